chunked_adder: RTL and testbench
================================

Name: chunked_adder

Overview:
- Multi-cycle, parametrised two's-complement adder/subtractor.
- Adds or subtracts two MAXN-bit operands CHUNK bits per clock, LSB chunk first, with the carry held in a register between chunks.
- Replaces the single-cycle ripple adder wherever a wide datapath would otherwise set the critical path.
- Uses a start/done handshake and also reports carry-out and signed overflow.

Parameters:
- MAXN, 16, operand and result width in bits. Must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle. Legal range is 1 to MAXN. NCHUNK = MAXN/CHUNK.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation. Sampled only while ready=1.
- sub  input  1  0 = x+y, 1 = x-y. Latched together with start.
- x  input  MAXN  operand A. Latched when start is accepted.
- y  input  MAXN  operand B. Latched when start is accepted.
- ready  output  1  high when idle and able to accept start.
- done  output  1  one-cycle pulse marking that the result is valid.
- sum  output  MAXN  result, modulo 2^MAXN.
- cout  output  1  carry out of the MSB. For subtraction, 1 means no borrow.
- ovf  output  1  signed overflow.

Behaviour:
- Reset, on any rising edge with rst=1 and regardless of state:
  - state=IDLE, ready=1, done=0, sum=0, cout=0, ovf=0.
  - Chunk index, carry register and operand registers are cleared.
  - An operation in progress is aborted and produces no done pulse.
- Reset has priority over start.
- States: IDLE and RUN.
- IDLE:
  - ready=1.
  - On an edge with start=1, latch x into A and sub ? ~y : y into B.
  - Carry register <= sub. Chunk index k <= 0. Go to RUN; ready=0 from the next cycle.
- RUN, one chunk per edge:
  - Add A[k*CHUNK +: CHUNK] + B[k*CHUNK +: CHUNK] + carry and store the chunk in an internal result register.
  - Carry <= chunk carry-out. k <= k+1.
- Last chunk (k = NCHUNK-1), on the same edge:
  - sum <= full internal result including this chunk.
  - cout <= MSB carry-out.
  - ovf <= (carry into MSB) XOR (carry out of MSB), computed inside the last chunk.
  - done <= 1 and state <= IDLE, so ready=1 and done=1 in the same cycle.
- done deasserts on the following edge.
- Latency: start sampled at edge E; done, sum, cout and ovf are valid in the cycle after edge E+NCHUNK. With the defaults NCHUNK=4.
- Throughput: one operation per NCHUNK+1 cycles. start may be asserted again in the same cycle that done is high; it is accepted because ready=1.
- sum, cout and ovf hold their values from the last completed operation until the next completion or reset. They never show partial results during RUN.
- start while ready=0 is ignored, with no queuing and no effect on the operation in flight.
- Changes to x, y or sub after acceptance have no effect.
- CHUNK = MAXN: NCHUNK=1 and RUN lasts one cycle. The chunk index register is still present, with width max(1, clog2(NCHUNK)).
- Carry into the MSB for ovf: when CHUNK=1 this is the carry register entering the last chunk. Otherwise it is the internal carry at bit CHUNK-1 of the last chunk.
- The result is identical to (x + (sub ? ~y : y) + sub) mod 2^(MAXN+1), split into sum and cout.

Test Plan:
- Defaults, x=0x1234, y=0x4321, sub=0, start for one cycle:
  - ready drops the next cycle.
  - done pulses exactly 4 cycles after acceptance with sum=0x5555, cout=0, ovf=0.
  - ready=1 in the same cycle as done.
- Carry and overflow corners:
  - 0xFFFF+0x0001 -> sum=0x0000, cout=1, ovf=0.
  - 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1.
  - 0x8000+0x8000 -> sum=0x0000, cout=1, ovf=1.
- Subtract:
  - 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1.
  - 0x0000-0x0001 -> sum=0xFFFF, cout=0, ovf=0.
  - 0x0005-0x0005 -> sum=0x0000, cout=1, ovf=0.
- Handshake:
  - Assert start with different operands on every cycle during RUN: only the first operation completes, with its original operands.
  - Start again in the done cycle: the second result arrives 5 cycles after the first done.
- Reset mid-operation:
  - Assert rst two cycles into RUN: the next cycle shows ready=1, done=0, sum=0, cout=0, ovf=0, and no done pulse ever appears for the aborted operation.
- Parameter sweep with 1000 random operands each, sum/cout/ovf checked against the reference model and latency checked:
  - MAXN=8, CHUNK=8: latency 1.
  - MAXN=32, CHUNK=1: latency 32.
  - MAXN=24, CHUNK=6: latency 4.

Source files
------------

// File: rtl/chunked_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// chunked_adder : multi-cycle adder/subtractor, CHUNK bits per clock, LSB first
// Rev 1.0
// ---------------------------------------------------------------------------
module chunked_adder #(
  parameter int MAXN  = 16,
  parameter int CHUNK = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            sub,
  input  logic [MAXN-1:0] x,
  input  logic [MAXN-1:0] y,
  output logic            ready,
  output logic            done,
  output logic [MAXN-1:0] sum,
  output logic            cout,
  output logic            ovf
);

  localparam int NCHUNK = MAXN / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] LAST_K = KW'(NCHUNK - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [MAXN-1:0] a_q, a_d;
  logic [MAXN-1:0] b_q, b_d;
  logic [MAXN-1:0] res_q, res_d;
  logic [MAXN-1:0] sum_q, sum_d;
  logic [KW-1:0]   k_q, k_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic            done_q, done_d;

  logic [CHUNK-1:0] w_a_ch;
  logic [CHUNK-1:0] w_b_ch;
  logic [CHUNK:0]   w_csum;
  logic             w_cmsb;

  always_comb begin
    w_a_ch = '0;
    w_b_ch = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (k_q == KW'(i)) begin
        w_a_ch = a_q[i*CHUNK +: CHUNK];
        w_b_ch = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  assign w_csum = {1'b0, w_a_ch} + {1'b0, w_b_ch} + {{CHUNK{1'b0}}, carry_q};
  // Carry into the top bit recovered from that bit's sum: s = a ^ b ^ cin.
  assign w_cmsb = w_a_ch[CHUNK-1] ^ w_b_ch[CHUNK-1] ^ w_csum[CHUNK-1];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    k_d     = k_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = x;
          b_d     = sub ? ~y : y;
          carry_d = sub;
          k_d     = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NCHUNK; i++) begin
          if (k_q == KW'(i)) begin
            res_d[i*CHUNK +: CHUNK] = w_csum[CHUNK-1:0];
          end
        end
        carry_d = w_csum[CHUNK];
        k_d     = k_q + 1'b1;
        if (k_q == LAST_K) begin
          sum_d   = res_d;
          cout_d  = w_csum[CHUNK];
          ovf_d   = w_cmsb ^ w_csum[CHUNK];
          done_d  = 1'b1;
          k_d     = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign done  = done_q;
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_chunked_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_chunked_adder : directed and random checks of chunked_adder
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_chunked_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start, sub;
  logic [15:0] x, y;
  logic        ready, done;
  logic [15:0] sum;
  logic        cout, ovf;

  logic [31:0] px, py;
  logic        psub;
  logic [2:0]  pstart;
  logic        r8_ready, r8_done, r8_cout, r8_ovf;
  logic [7:0]  r8_sum;
  logic        r32_ready, r32_done, r32_cout, r32_ovf;
  logic [31:0] r32_sum;
  logic        r24_ready, r24_done, r24_cout, r24_ovf;
  logic [23:0] r24_sum;

  int n_tests = 0;
  int n_fail  = 0;

  chunked_adder #(.MAXN(16), .CHUNK(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .x(x), .y(y),
    .ready(ready), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  chunked_adder #(.MAXN(8), .CHUNK(8)) u_w8 (
    .clk(clk), .rst(rst), .start(pstart[0]), .sub(psub), .x(px[7:0]), .y(py[7:0]),
    .ready(r8_ready), .done(r8_done), .sum(r8_sum), .cout(r8_cout), .ovf(r8_ovf)
  );

  chunked_adder #(.MAXN(32), .CHUNK(1)) u_w32 (
    .clk(clk), .rst(rst), .start(pstart[1]), .sub(psub), .x(px), .y(py),
    .ready(r32_ready), .done(r32_done), .sum(r32_sum), .cout(r32_cout), .ovf(r32_ovf)
  );

  chunked_adder #(.MAXN(24), .CHUNK(6)) u_w24 (
    .clk(clk), .rst(rst), .start(pstart[2]), .sub(psub), .x(px[23:0]), .y(py[23:0]),
    .ready(r24_ready), .done(r24_done), .sum(r24_sum), .cout(r24_cout), .ovf(r24_ovf)
  );

  int          sel;
  logic [31:0] q_sum;
  logic        q_done, q_ready, q_cout, q_ovf;

  always_comb begin
    q_sum   = '0;
    q_done  = 1'b0;
    q_ready = 1'b0;
    q_cout  = 1'b0;
    q_ovf   = 1'b0;
    case (sel)
      0: begin
        q_sum = {24'b0, r8_sum}; q_done = r8_done; q_ready = r8_ready;
        q_cout = r8_cout; q_ovf = r8_ovf;
      end
      1: begin
        q_sum = r32_sum; q_done = r32_done; q_ready = r32_ready;
        q_cout = r32_cout; q_ovf = r32_ovf;
      end
      default: begin
        q_sum = {8'b0, r24_sum}; q_done = r24_done; q_ready = r24_ready;
        q_cout = r24_cout; q_ovf = r24_ovf;
      end
    endcase
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [15:0] es;
    logic        ec;
    logic        eo;
  } vec_t;

  vec_t corners[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation on the 16/4 instance, scrambles inputs after
  // acceptance, and waits (bounded) for done.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic sb,
                       output int lat, output logic rdy_drop, output logic rdy_done);
    x = a; y = b; sub = sb; start = 1'b1;
    step();
    start = 1'b0; x = ~a; y = ~b; sub = ~sb;
    rdy_drop = ~ready;
    rdy_done = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (done) begin
        lat = c;
        rdy_done = ready;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    step(); step();
    rst = 1'b0;
    n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, expected 1", ready); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, expected 0", done); end
    n_tests++; if (sum !== 16'h0000) begin n_fail++; $display("FAIL reset_sum: got %h, expected 0000", sum); end
    n_tests++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b, expected 0", cout); end
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b, expected 0", ovf); end
  endtask

  task automatic test_basic();
    int   lat;
    logic rd, rdd;
    do_op(16'h1234, 16'h4321, 1'b0, lat, rd, rdd);
    n_tests++; if (rd !== 1'b1) begin n_fail++; $display("FAIL basic_ready_drop: got %b, expected 1", rd); end
    n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL basic_latency: got %0d, expected 4", lat); end
    n_tests++; if (rdd !== 1'b1) begin n_fail++; $display("FAIL basic_ready_at_done: got %b, expected 1", rdd); end
    n_tests++; if (sum !== 16'h5555) begin n_fail++; $display("FAIL basic_sum: got %h, expected 5555", sum); end
    n_tests++; if (cout !== 1'b0) begin n_fail++; $display("FAIL basic_cout: got %b, expected 0", cout); end
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL basic_ovf: got %b, expected 0", ovf); end
  endtask

  task automatic test_corners();
    int   lat;
    logic rd, rdd;
    corners[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    corners[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    corners[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    corners[3] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    corners[4] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    corners[5] = '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      do_op(corners[i].a, corners[i].b, corners[i].s, lat, rd, rdd);
      n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL corner%0d_latency: got %0d, expected 4", i, lat); end
      n_tests++; if (sum !== corners[i].es) begin n_fail++; $display("FAIL corner%0d_sum: got %h, expected %h", i, sum, corners[i].es); end
      n_tests++; if (cout !== corners[i].ec) begin n_fail++; $display("FAIL corner%0d_cout: got %b, expected %b", i, cout, corners[i].ec); end
      n_tests++; if (ovf !== corners[i].eo) begin n_fail++; $display("FAIL corner%0d_ovf: got %b, expected %b", i, ovf, corners[i].eo); end
    end
  endtask

  task automatic test_handshake();
    int lat = -1;
    int extra_done = 0;
    int ready_low = 0;
    x = 16'h0101; y = 16'h0202; sub = 1'b0; start = 1'b1;
    step();
    for (int c = 1; c <= 20; c++) begin
      x = 16'($urandom); y = 16'($urandom); sub = 1'($urandom); start = 1'b1;
      step();
      if (done) begin lat = c; break; end
    end
    start = 1'b0;
    n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL hs_latency: got %0d, expected 4", lat); end
    n_tests++; if (sum !== 16'h0303) begin n_fail++; $display("FAIL hs_sum: got %h, expected 0303", sum); end
    n_tests++; if (cout !== 1'b0) begin n_fail++; $display("FAIL hs_cout: got %b, expected 0", cout); end
    for (int c = 0; c < 8; c++) begin
      step();
      if (done) extra_done++;
      if (!ready) ready_low++;
    end
    n_tests++; if (extra_done !== 0) begin n_fail++; $display("FAIL hs_extra_done: got %0d, expected 0", extra_done); end
    n_tests++; if (ready_low !== 0) begin n_fail++; $display("FAIL hs_queued_op: got %0d busy cycles, expected 0", ready_low); end
  endtask

  task automatic test_back_to_back();
    int   lat, gap;
    int   partial = 0;
    logic rd, rdd;
    do_op(16'h1111, 16'h2222, 1'b0, lat, rd, rdd);
    n_tests++; if (sum !== 16'h3333) begin n_fail++; $display("FAIL b2b_first_sum: got %h, expected 3333", sum); end
    x = 16'h0F0F; y = 16'h0101; sub = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL b2b_accept: got ready=%b, expected 0", ready); end
    gap = 1;
    for (int c = 0; c < 20; c++) begin
      if (!done && sum !== 16'h3333) partial++;
      step();
      gap++;
      if (done) break;
    end
    n_tests++; if (gap !== 5) begin n_fail++; $display("FAIL b2b_gap: got %0d, expected 5", gap); end
    n_tests++; if (sum !== 16'h1010) begin n_fail++; $display("FAIL b2b_second_sum: got %h, expected 1010", sum); end
    n_tests++; if (partial !== 0) begin n_fail++; $display("FAIL b2b_sum_hold: got %0d changed cycles, expected 0", partial); end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    x = 16'hABCD; y = 16'h1357; sub = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b, expected 1", ready); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rmid_done: got %b, expected 0", done); end
    n_tests++; if (sum !== 16'h0000) begin n_fail++; $display("FAIL rmid_sum: got %h, expected 0000", sum); end
    n_tests++; if (cout !== 1'b0) begin n_fail++; $display("FAIL rmid_cout: got %b, expected 0", cout); end
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL rmid_ovf: got %b, expected 0", ovf); end
    for (int c = 0; c < 10; c++) begin
      step();
      if (done) dones++;
    end
    n_tests++; if (dones !== 0) begin n_fail++; $display("FAIL rmid_no_done: got %0d pulses, expected 0", dones); end
  endtask

  task automatic test_sweep(input int which, input int w, input int nch);
    logic [63:0] mask, a, b, bb, full, es;
    logic        s, ec, eo;
    int          lat;
    sel  = which;
    mask = (64'd1 << w) - 64'd1;
    for (int it = 0; it < 1000; it++) begin
      a = {32'b0, $urandom} & mask;
      b = {32'b0, $urandom} & mask;
      s = 1'($urandom);
      px = a[31:0]; py = b[31:0]; psub = s;
      pstart = 3'b000; pstart[which] = 1'b1;
      step();
      pstart = 3'b000; px = ~px; py = ~py; psub = ~s;
      lat = -1;
      for (int c = 1; c <= 40; c++) begin
        step();
        if (q_done) begin lat = c; break; end
      end
      bb   = s ? (~b & mask) : b;
      full = a + bb + {63'b0, s};
      es   = full & mask;
      ec   = full[w];
      eo   = (a[w-1] == bb[w-1]) && (es[w-1] != a[w-1]);
      n_tests++; if (lat !== nch) begin n_fail++; $display("FAIL sweep%0d_it%0d_latency: got %0d, expected %0d", w, it, lat, nch); end
      n_tests++; if (q_ready !== 1'b1) begin n_fail++; $display("FAIL sweep%0d_it%0d_ready: got %b, expected 1", w, it, q_ready); end
      n_tests++; if ({32'b0, q_sum} !== es) begin n_fail++; $display("FAIL sweep%0d_it%0d_sum: got %h, expected %h", w, it, q_sum, es); end
      n_tests++; if (q_cout !== ec) begin n_fail++; $display("FAIL sweep%0d_it%0d_cout: got %b, expected %b", w, it, q_cout, ec); end
      n_tests++; if (q_ovf !== eo) begin n_fail++; $display("FAIL sweep%0d_it%0d_ovf: got %b, expected %b", w, it, q_ovf, eo); end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; x = '0; y = '0;
    px = '0; py = '0; psub = 1'b0; pstart = 3'b000; sel = 0;
    test_reset();
    test_basic();
    test_corners();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    test_sweep(0, 8, 1);
    test_sweep(1, 32, 32);
    test_sweep(2, 24, 4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
